sa_sequencer: RTL and testbench
===============================

Name: sa_sequencer

Overview:
Controller that runs one complete pass of the systolic_array: a weight-load phase, a one-cycle ready pulse, skewed feature streaming, and a drain phase. It sits between the weight/feature buffers and the array. It drives load_i, ready_i, start_op_i, f_weight_i and in_feature_i, and marks valid result cycles. Row r of each feature vector is delayed r cycles internally, so upstream always supplies unskewed vectors.

Parameters:
N_ROWS_ARRAY, 4, array rows
N_COLS_ARRAY, 4, array columns
I_WIDTH, 8, feature element width
F_WIDTH, 8, weight element width
CNT_WIDTH, 8, width of weight-word and vector counters
RES_LAT, 2, cycles from a row-0 feature entering the array to its result on result

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  begin pass; sampled only in IDLE
num_w_i  in  CNT_WIDTH  weight words to load; latched at start
num_vec_i  in  CNT_WIDTH  feature vectors to stream; latched at start
w_data_i  in  N_COLS_ARRAY*F_WIDTH  weight word, column c at bits [c*F_WIDTH +: F_WIDTH]
w_valid_i  in  1  weight word available
w_ready_o  out  1  weight word accepted this cycle when high with w_valid_i
f_data_i  in  N_ROWS_ARRAY*I_WIDTH  unskewed feature vector, row r at [r*I_WIDTH +: I_WIDTH]
f_valid_i  in  1  feature vector available
f_ready_o  out  1  feature vector accepted this cycle when high with f_valid_i
load_o  out  1  to array load_i
ready_o  out  1  to array ready_i
start_op_o  out  N_ROWS_ARRAY  to array start_op_i, bit r = row r
f_weight_o  out  N_COLS_ARRAY*F_WIDTH  to array f_weight_i
in_feature_o  out  N_ROWS_ARRAY*I_WIDTH  to array in_feature_i, skewed
result_valid_o  out  1  result is valid this cycle
busy_o  out  1  high when not IDLE
done_o  out  1  one-cycle pulse at end of pass
underrun_o  out  1  sticky; set on a STREAM bubble, cleared on start

Behaviour:
- Reset (asynchronous): state goes to IDLE. All outputs, counters, skew registers and the valid shift register are cleared to 0.
- Registered array outputs: load_o, ready_o, start_op_o, f_weight_o and in_feature_o are all registered.
- States: IDLE, LOAD, READY, STREAM, DRAIN, DONE.
- IDLE:
  - start_i=1 latches num_w_i and num_vec_i and clears underrun_o.
  - Next state is LOAD, or READY if num_w_i=0.
  - start_i is ignored in every other state.
- LOAD:
  - w_ready_o=1.
  - On each accepted word, f_weight_o<=w_data_i and load_o<=1. Otherwise load_o<=0 and f_weight_o holds.
  - After num_w words are accepted, go to READY.
- READY: ready_o=1 for exactly one cycle, f_weight_o<=0, load_o<=0. Next state is STREAM, or DRAIN if num_vec=0.
- STREAM:
  - f_ready_o=1.
  - Row 0 register takes the accepted f_data row 0. Row r passes through r skew stages (row r output lags row 0 by r cycles).
  - If f_valid_i=0, a zero vector is injected, is not counted, and sets underrun_o.
  - start_op_o bit r rises on the r-th cycle after STREAM entry (staircase) and stays high until DONE.
  - After num_vec vectors are accepted, go to DRAIN.
- DRAIN:
  - Zeros are fed into the skew chain.
  - Stays until every row's start_op bit is set and the valid shift register is empty; then DONE.
- result_valid_o: the per-cycle "accepted vector" flag delayed by RES_LAT+N_ROWS_ARRAY-1 cycles through a shift register. There are exactly num_vec pulses per pass, with bubbles preserved.
- DONE: done_o=1 for one cycle, start_op_o<=0, then IDLE.
- Counter overflow cannot occur: counters are compared against the latched sizes, which are at most 2^CNT_WIDTH-1.
- Reset mid-pass: abort immediately, with no done_o pulse.

Optional Feature:
SA_SEQ_PERF_CNT_EN:
- Defined: adds outputs cycle_cnt_o[31:0] (cycles spent busy in the last pass) and stall_cnt_o[31:0] (LOAD cycles with w_valid_i=0 plus STREAM bubbles). Both clear on start, saturate at all-ones, and hold their value after done.
- Undefined: these ports and the logic behind them do not exist; all other behaviour is identical.

Test Plan:
- Defaults, num_w=4, num_vec=4, all valids tied high:
  - load_o is high for 4 cycles carrying words 0..3, then ready_o pulses once.
  - start_op_o steps 0001, 0011, 0111, 1111.
  - in_feature_o row 3 shows vector 0 three cycles after row 0.
  - 4 result_valid_o pulses, the first 5 cycles after the first accept; then done_o.
- Weight stall (w_valid_i low for 2 cycles mid-LOAD): load_o drops for those 2 cycles, f_weight_o holds, 4 words are still loaded, and ready_o is delayed by 2.
- Feature bubble (f_valid_i low for 1 cycle after vector 1):
  - A zero vector appears skewed on all rows and underrun_o=1.
  - Exactly 4 result_valid_o pulses, with a 1-cycle gap.
- Zero sizes: num_w=0 goes IDLE to READY directly. num_w=0 with num_vec=0 gives the sequence READY, DRAIN, DONE, with no result_valid_o and done_o after 5 cycles.
- Reset asserted in STREAM: all outputs are 0 immediately, asynchronously, with no done_o. A fresh start then completes normally.
- start_i pulsed while busy_o=1: ignored, latched sizes unchanged. With SA_SEQ_PERF_CNT_EN, run 1 gives stall_cnt_o=2 and cycle_cnt_o matching the measured busy_o cycles.

Source files
------------

// File: rtl/sa_sequencer_if.sv
// Signal bundle between sa_sequencer, its weight/feature buffers and the systolic array.
// Perf counter signals exist only when SA_SEQ_PERF_CNT_EN is defined.
interface sa_sequencer_if #(
    parameter int unsigned N_ROWS_ARRAY = 4,
    parameter int unsigned N_COLS_ARRAY = 4,
    parameter int unsigned I_WIDTH      = 8,
    parameter int unsigned F_WIDTH      = 8,
    parameter int unsigned CNT_WIDTH    = 8
);
    logic                             start_i;
    logic [CNT_WIDTH-1:0]             num_w_i;
    logic [CNT_WIDTH-1:0]             num_vec_i;
    logic [N_COLS_ARRAY*F_WIDTH-1:0]  w_data_i;
    logic                             w_valid_i;
    logic                             w_ready_o;
    logic [N_ROWS_ARRAY*I_WIDTH-1:0]  f_data_i;
    logic                             f_valid_i;
    logic                             f_ready_o;
    logic                             load_o;
    logic                             ready_o;
    logic [N_ROWS_ARRAY-1:0]          start_op_o;
    logic [N_COLS_ARRAY*F_WIDTH-1:0]  f_weight_o;
    logic [N_ROWS_ARRAY*I_WIDTH-1:0]  in_feature_o;
    logic                             result_valid_o;
    logic                             busy_o;
    logic                             done_o;
    logic                             underrun_o;
`ifdef SA_SEQ_PERF_CNT_EN
    logic [31:0]                      cycle_cnt_o;
    logic [31:0]                      stall_cnt_o;
`endif

    modport master (
        output start_i, num_w_i, num_vec_i, w_data_i, w_valid_i, f_data_i, f_valid_i,
        input  w_ready_o, f_ready_o, load_o, ready_o, start_op_o, f_weight_o, in_feature_o,
        input  result_valid_o, busy_o, done_o, underrun_o
`ifdef SA_SEQ_PERF_CNT_EN
        , input cycle_cnt_o, stall_cnt_o
`endif
    );

    modport slave (
        input  start_i, num_w_i, num_vec_i, w_data_i, w_valid_i, f_data_i, f_valid_i,
        output w_ready_o, f_ready_o, load_o, ready_o, start_op_o, f_weight_o, in_feature_o,
        output result_valid_o, busy_o, done_o, underrun_o
`ifdef SA_SEQ_PERF_CNT_EN
        , output cycle_cnt_o, stall_cnt_o
`endif
    );
endinterface

// File: rtl/sa_sequencer.sv
// One-pass controller for the systolic array: weight load, ready pulse, skewed feature
// streaming and drain. Optional busy/stall counters when SA_SEQ_PERF_CNT_EN is defined.
module sa_sequencer #(
    parameter int unsigned N_ROWS_ARRAY = 4,
    parameter int unsigned N_COLS_ARRAY = 4,
    parameter int unsigned I_WIDTH      = 8,
    parameter int unsigned F_WIDTH      = 8,
    parameter int unsigned CNT_WIDTH    = 8,
    parameter int unsigned RES_LAT      = 2
) (
    input logic           clk_i,
    input logic           rst_i,
    sa_sequencer_if.slave bus
);
    localparam int unsigned VLAT = RES_LAT + N_ROWS_ARRAY - 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    typedef enum logic [2:0] {StIdle, StLoad, StReady, StStream, StDrain, StDone} state_e;

    state_e                          r_state, w_state_next;
    logic [CNT_WIDTH-1:0]            r_num_w, r_num_v, r_w_cnt, r_v_cnt;
    logic                            r_load, r_ready, r_underrun;
    logic [N_ROWS_ARRAY-1:0]         r_start_op;
    logic [N_COLS_ARRAY*F_WIDTH-1:0] r_f_weight;
    logic [VLAT-1:0]                 r_vsr;
    logic [N_ROWS_ARRAY*I_WIDTH-1:0] w_in_feature;
    logic                            w_start, w_w_acc, w_f_acc;
    logic                            w_w_ready, w_f_ready, w_busy, w_done;

    assign w_start = (r_state == StIdle) && bus.start_i;
    assign w_w_acc = (r_state == StLoad) && bus.w_valid_i;
    assign w_f_acc = (r_state == StStream) && bus.f_valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (bus.start_i) w_state_next = (bus.num_w_i == '0) ? StReady : StLoad;
            StLoad:   if (w_w_acc && (r_w_cnt + CNT_ONE == r_num_w)) w_state_next = StReady;
            StReady:  w_state_next = (r_num_v == '0) ? StDrain : StStream;
            StStream: if (w_f_acc && (r_v_cnt + CNT_ONE == r_num_v)) w_state_next = StDrain;
            StDrain:  if ((&r_start_op) && (r_vsr == '0)) w_state_next = StDone;
            StDone:   w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_w_ready = (r_state == StLoad);
        w_f_ready = (r_state == StStream);
        w_busy    = (r_state != StIdle);
        w_done    = (r_state == StDone);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_num_w    <= '0;
            r_num_v    <= '0;
            r_w_cnt    <= '0;
            r_v_cnt    <= '0;
            r_load     <= 1'b0;
            r_ready    <= 1'b0;
            r_underrun <= 1'b0;
            r_start_op <= '0;
            r_f_weight <= '0;
        end else begin
            r_load  <= 1'b0;
            r_ready <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (bus.start_i) begin
                        r_num_w    <= bus.num_w_i;
                        r_num_v    <= bus.num_vec_i;
                        r_w_cnt    <= '0;
                        r_v_cnt    <= '0;
                        r_underrun <= 1'b0;
                    end
                end
                StLoad: begin
                    if (w_w_acc) begin
                        r_f_weight <= bus.w_data_i;
                        r_load     <= 1'b1;
                        r_w_cnt    <= r_w_cnt + CNT_ONE;
                    end
                end
                StReady: begin
                    r_ready    <= 1'b1;
                    r_f_weight <= '0;
                end
                StStream: begin
                    // Staircase: bit r goes high together with row r's first skewed element
                    r_start_op <= (r_start_op << 1) | N_ROWS_ARRAY'(1);
                    if (w_f_acc) r_v_cnt    <= r_v_cnt + CNT_ONE;
                    else         r_underrun <= 1'b1;
                end
                StDrain: r_start_op <= (r_start_op << 1) | N_ROWS_ARRAY'(1);
                StDone:  r_start_op <= '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_vsr <= '0;
        else       r_vsr <= {r_vsr[VLAT-2:0], w_f_acc};
    end

    // Row r: r skew stages plus the output register; bubbles and drain inject zeros.
    for (genvar gr = 0; gr < N_ROWS_ARRAY; gr++) begin : g_row
        logic [I_WIDTH-1:0] w_row_in;
        logic [I_WIDTH-1:0] r_pipe [gr+1];

        assign w_row_in = w_f_acc ? bus.f_data_i[gr*I_WIDTH +: I_WIDTH] : '0;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int k = 0; k <= gr; k++) r_pipe[k] <= '0;
            end else begin
                r_pipe[0] <= w_row_in;
                for (int k = 1; k <= gr; k++) r_pipe[k] <= r_pipe[k-1];
            end
        end

        assign w_in_feature[gr*I_WIDTH +: I_WIDTH] = r_pipe[gr];
    end

`ifdef SA_SEQ_PERF_CNT_EN
    logic [31:0] r_cycle_cnt, r_stall_cnt;
    logic        w_stall;

    assign w_stall = ((r_state == StLoad) && !bus.w_valid_i) ||
                     ((r_state == StStream) && !bus.f_valid_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
        end else if (w_start) begin
            r_cycle_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_busy && (r_cycle_cnt != '1)) r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign bus.cycle_cnt_o = r_cycle_cnt;
    assign bus.stall_cnt_o = r_stall_cnt;
`endif

    assign bus.w_ready_o      = w_w_ready;
    assign bus.f_ready_o      = w_f_ready;
    assign bus.busy_o         = w_busy;
    assign bus.done_o         = w_done;
    assign bus.load_o         = r_load;
    assign bus.ready_o        = r_ready;
    assign bus.start_op_o     = r_start_op;
    assign bus.f_weight_o     = r_f_weight;
    assign bus.in_feature_o   = w_in_feature;
    assign bus.result_valid_o = r_vsr[VLAT-1];
    assign bus.underrun_o     = r_underrun;
endmodule

// File: tb/tb_sa_sequencer.sv
// Directed bench for sa_sequencer: per-cycle vector table for a nominal pass plus
// recorded multi-cycle runs for stalls, bubbles, zero sizes, reset and ignored starts.
module tb_sa_sequencer;
    localparam int NCYC = 30;

    logic clk_i;
    logic rst_i;
    int   n_checks;
    int   n_errors;
    int   wi;
    int   fi;

    sa_sequencer_if bus ();

    sa_sequencer u_dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ctl = {load, ready, result_valid, done, busy, w_ready, f_ready}
    typedef struct {
        logic        start;
        logic [6:0]  ctl;
        logic [3:0]  sop;
        logic [31:0] fw;
        logic [31:0] feat;
    } vec_t;

    vec_t tbl [18];

    logic [NCYC-1:0] rec_load, rec_ready, rec_rv, rec_done, rec_busy, rec_under;
    logic [31:0]     rec_fw   [NCYC];
    logic [31:0]     rec_feat [NCYC];

    function automatic vec_t mk(input logic st, input logic [6:0] ctl, input logic [3:0] sop,
                                input logic [31:0] fw, input logic [31:0] feat);
        vec_t v;
        v.start = st;
        v.ctl   = ctl;
        v.sop   = sop;
        v.fw    = fw;
        v.feat  = feat;
        return v;
    endfunction

    function automatic logic [31:0] wword(input int i);
        logic [31:0] w;
        for (int c = 0; c < 4; c++) w[c*8 +: 8] = 8'(16 * i + c);
        return w;
    endfunction

    function automatic logic [31:0] fvec(input int i);
        logic [31:0] f;
        for (int r = 0; r < 4; r++) f[r*8 +: 8] = 8'(128 + 16 * i + r);
        return f;
    endfunction

    function automatic int first_one(input logic [NCYC-1:0] v);
        for (int i = 0; i < NCYC; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        logic aw, af;
        aw = bus.w_valid_i && bus.w_ready_o;
        af = bus.f_valid_i && bus.f_ready_o;
        @(posedge clk_i);
        #1;
        if (aw) wi++;
        if (af) fi++;
        bus.w_data_i = wword(wi);
        bus.f_data_i = fvec(fi);
    endtask

    task automatic run(input logic [7:0] nw, input logic [7:0] nv, input logic [NCYC-1:0] wv_off,
                       input logic [NCYC-1:0] fv_off, input int extra_start);
        wi = 0;
        fi = 0;
        bus.w_data_i = wword(0);
        bus.f_data_i = fvec(0);
        for (int k = 0; k < NCYC; k++) begin
            bus.start_i   = (k == 0) || (k == extra_start);
            bus.num_w_i   = (k == 0) ? nw : 8'd9;
            bus.num_vec_i = (k == 0) ? nv : 8'd9;
            bus.w_valid_i = !wv_off[k];
            bus.f_valid_i = !fv_off[k];
            rec_load[k]   = bus.load_o;
            rec_ready[k]  = bus.ready_o;
            rec_rv[k]     = bus.result_valid_o;
            rec_done[k]   = bus.done_o;
            rec_busy[k]   = bus.busy_o;
            rec_under[k]  = bus.underrun_o;
            rec_fw[k]     = bus.f_weight_o;
            rec_feat[k]   = bus.in_feature_o;
            tick();
        end
        bus.start_i = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        wi = 0;
        fi = 0;
        rst_i = 1'b1;
        bus.start_i = 1'b0;
        bus.num_w_i = 8'd0;
        bus.num_vec_i = 8'd0;
        bus.w_valid_i = 1'b0;
        bus.f_valid_i = 1'b0;
        bus.w_data_i = wword(0);
        bus.f_data_i = fvec(0);

        tbl[0]  = mk(1'b1, 7'b0000000, 4'h0, 32'h0,        32'h0);
        tbl[1]  = mk(1'b0, 7'b0000110, 4'h0, 32'h0,        32'h0);
        tbl[2]  = mk(1'b0, 7'b1000110, 4'h0, 32'h03020100, 32'h0);
        tbl[3]  = mk(1'b0, 7'b1000110, 4'h0, 32'h13121110, 32'h0);
        tbl[4]  = mk(1'b0, 7'b1000110, 4'h0, 32'h23222120, 32'h0);
        tbl[5]  = mk(1'b0, 7'b1000100, 4'h0, 32'h33323130, 32'h0);
        tbl[6]  = mk(1'b0, 7'b0100101, 4'h0, 32'h0,        32'h0);
        tbl[7]  = mk(1'b0, 7'b0000101, 4'h1, 32'h0,        32'h00000080);
        tbl[8]  = mk(1'b0, 7'b0000101, 4'h3, 32'h0,        32'h00008190);
        tbl[9]  = mk(1'b0, 7'b0000101, 4'h7, 32'h0,        32'h008291A0);
        tbl[10] = mk(1'b0, 7'b0000100, 4'hF, 32'h0,        32'h8392A1B0);
        tbl[11] = mk(1'b0, 7'b0010100, 4'hF, 32'h0,        32'h93A2B100);
        tbl[12] = mk(1'b0, 7'b0010100, 4'hF, 32'h0,        32'hA3B20000);
        tbl[13] = mk(1'b0, 7'b0010100, 4'hF, 32'h0,        32'hB3000000);
        tbl[14] = mk(1'b0, 7'b0010100, 4'hF, 32'h0,        32'h0);
        tbl[15] = mk(1'b0, 7'b0000100, 4'hF, 32'h0,        32'h0);
        tbl[16] = mk(1'b0, 7'b0001100, 4'hF, 32'h0,        32'h0);
        tbl[17] = mk(1'b0, 7'b0000000, 4'h0, 32'h0,        32'h0);

        @(posedge clk_i);
        #1;
        chk("reset_ctl", 64'({bus.load_o, bus.ready_o, bus.result_valid_o, bus.done_o,
                              bus.busy_o, bus.w_ready_o, bus.f_ready_o, bus.underrun_o}), 64'h0);
        chk("reset_data", 64'({bus.start_op_o, bus.f_weight_o, bus.in_feature_o}), 64'h0);
        rst_i = 1'b0;
        tick();

        // Nominal pass, every cycle compared against the table
        bus.w_valid_i = 1'b1;
        bus.f_valid_i = 1'b1;
        for (int k = 0; k < 18; k++) begin
            bus.start_i   = tbl[k].start;
            bus.num_w_i   = tbl[k].start ? 8'd4 : 8'd9;
            bus.num_vec_i = tbl[k].start ? 8'd4 : 8'd9;
            chk($sformatf("main[%0d].ctl_sop", k),
                64'({bus.load_o, bus.ready_o, bus.result_valid_o, bus.done_o, bus.busy_o,
                     bus.w_ready_o, bus.f_ready_o, bus.start_op_o}),
                64'({tbl[k].ctl, tbl[k].sop}));
            chk($sformatf("main[%0d].f_weight", k), 64'(bus.f_weight_o), 64'(tbl[k].fw));
            chk($sformatf("main[%0d].in_feature", k), 64'(bus.in_feature_o), 64'(tbl[k].feat));
            tick();
        end
        chk("main.underrun", 64'(bus.underrun_o), 64'h0);

        // Weight stall in cycles 2-3
        run(8'd4, 8'd4, NCYC'(32'h0000_000C), '0, -1);
        chk("wstall.load_gap", 64'({rec_load[3], rec_load[4]}), 64'h0);
        chk("wstall.fw_hold3", 64'(rec_fw[3]), 64'h03020100);
        chk("wstall.fw_hold4", 64'(rec_fw[4]), 64'h03020100);
        chk("wstall.fw_last", 64'(rec_fw[7]), 64'h33323130);
        chk("wstall.n_load", 64'($countones(rec_load)), 64'd4);
        chk("wstall.ready_at", 64'(first_one(rec_ready)), 64'd8);
        chk("wstall.n_rv", 64'($countones(rec_rv)), 64'd4);
        chk("wstall.done_at", 64'(first_one(rec_done)), 64'd18);
`ifdef SA_SEQ_PERF_CNT_EN
        chk("perf.cycles_vs_busy", 64'(bus.cycle_cnt_o), 64'($countones(rec_busy)));
        chk("perf.cycles", 64'(bus.cycle_cnt_o), 64'd18);
        chk("perf.stalls", 64'(bus.stall_cnt_o), 64'd2);
`endif

        // Feature bubble in cycle 8
        run(8'd4, 8'd4, '0, NCYC'(32'h0000_0100), -1);
        chk("bubble.under_before", 64'(rec_under[8]), 64'h0);
        chk("bubble.under_set", 64'(rec_under[9]), 64'h1);
        chk("bubble.feat9", 64'(rec_feat[9]), 64'h00829100);
        chk("bubble.feat10", 64'(rec_feat[10]), 64'h839200A0);
        chk("bubble.feat11", 64'(rec_feat[11]), 64'h9300A1B0);
        chk("bubble.feat12", 64'(rec_feat[12]), 64'h00A2B100);
        chk("bubble.rv_gap", 64'(rec_rv[15:11]), 64'b11011);
        chk("bubble.n_rv", 64'($countones(rec_rv)), 64'd4);
        chk("bubble.done_at", 64'(first_one(rec_done)), 64'd17);
        chk("bubble.under_sticky", 64'(rec_under[NCYC-1]), 64'h1);

        // No weights: straight to READY
        run(8'd0, 8'd4, '0, '0, -1);
        chk("now.under_kept_idle", 64'(rec_under[0]), 64'h1);
        chk("now.under_cleared", 64'(rec_under[1]), 64'h0);
        chk("now.busy1", 64'(rec_busy[1]), 64'h1);
        chk("now.n_load", 64'($countones(rec_load)), 64'd0);
        chk("now.ready_at", 64'(first_one(rec_ready)), 64'd2);
        chk("now.n_rv", 64'($countones(rec_rv)), 64'd4);
        chk("now.done_at", 64'(first_one(rec_done)), 64'd12);

        // No weights, no vectors: READY, DRAIN, DONE
        run(8'd0, 8'd0, '0, '0, -1);
        chk("zero.ready_at", 64'(first_one(rec_ready)), 64'd2);
        chk("zero.ready_to_done",
            64'(first_one(rec_done) - first_one(rec_ready)), 64'd5);
        chk("zero.n_rv", 64'($countones(rec_rv)), 64'd0);
        chk("zero.n_done", 64'($countones(rec_done)), 64'd1);

        // Asynchronous reset in STREAM
        wi = 0;
        fi = 0;
        bus.w_data_i = wword(0);
        bus.f_data_i = fvec(0);
        bus.w_valid_i = 1'b1;
        bus.f_valid_i = 1'b1;
        bus.num_w_i = 8'd4;
        bus.num_vec_i = 8'd4;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int k = 1; k < 7; k++) tick();
        chk("rst.pre_sop", 64'(bus.start_op_o), 64'h1);
        #3;
        rst_i = 1'b1;
        #1;
        chk("rst.async_ctl", 64'({bus.load_o, bus.ready_o, bus.result_valid_o, bus.done_o,
                                  bus.busy_o, bus.w_ready_o, bus.f_ready_o, bus.underrun_o}),
            64'h0);
        chk("rst.async_data", 64'({bus.start_op_o, bus.f_weight_o, bus.in_feature_o}), 64'h0);
        @(posedge clk_i);
        #1;
        chk("rst.no_done", 64'(bus.done_o), 64'h0);
        rst_i = 1'b0;
        tick();
        run(8'd4, 8'd4, '0, '0, -1);
        chk("rst.fresh_n_rv", 64'($countones(rec_rv)), 64'd4);
        chk("rst.fresh_done_at", 64'(first_one(rec_done)), 64'd16);

        // start_i pulsed mid-LOAD with different sizes on the bus
        run(8'd4, 8'd4, '0, '0, 3);
        chk("busy_start.n_load", 64'($countones(rec_load)), 64'd4);
        chk("busy_start.n_rv", 64'($countones(rec_rv)), 64'd4);
        chk("busy_start.done_at", 64'(first_one(rec_done)), 64'd16);
        chk("busy_start.n_done", 64'($countones(rec_done)), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
